// File: rtl/direction_queue.sv
// direction_queue: turns button presses into a worm heading, one change per tick.
// Edge-detects presses, rejects same/opposite turns relative to the last queued
// heading (or the live heading when the queue is empty), and buffers accepted
// turns in a small circular queue so that quick double-turns are not lost.
// Optional feature: define DIRQ_DROP_COUNT_EN to add a saturating count of
// rejected presses on drop_count.
module direction_queue #(
    parameter int         DEPTH     = 2,
    parameter logic [1:0] RESET_DIR = 2'b11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_pushed,
    input  logic [1:0] button_state,
    input  logic       tick,
    input  logic       flush,
    output logic [1:0] heading,
    output logic       turned,
`ifdef DIRQ_DROP_COUNT_EN
    output logic [7:0] drop_count,
`endif
    output logic [1:0] queue_count
);

    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [1:0]    DEPTH_C = 2'(DEPTH);

    logic [1:0]    q_q [DEPTH];
    logic [1:0]    q_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [1:0]    count_q, count_d;
    logic [1:0]    heading_q, heading_d;
    logic          turned_q, turned_d;
    logic          pushed_q, pushed_d;
    logic [7:0]    drop_q, drop_d;

    logic          press_evt;
    logic          pop;
    logic          full;
    logic          accept;
    logic [PW-1:0] last_idx;
    logic [1:0]    ref_dir;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Accept decision, queue push/pop and heading update.
    always_comb begin
        pushed_d  = button_pushed;
        press_evt = button_pushed & ~pushed_q;
        last_idx  = (tail_q == '0) ? LAST : tail_q - 1'b1;
        ref_dir   = (count_q != 2'd0) ? q_q[last_idx] : heading_q;
        pop       = tick && (count_q != 2'd0);
        full      = (count_q == DEPTH_C);
        accept    = press_evt
                    && (button_state != ref_dir)
                    && (button_state != (ref_dir ^ 2'b01))
                    && (!full || pop);

        q_d       = q_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        heading_d = heading_q;
        turned_d  = 1'b0;
        drop_d    = drop_q;

        if (flush) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = 2'd0;
            heading_d = RESET_DIR;
            drop_d    = 8'd0;
        end else begin
            if (pop) begin
                heading_d = q_q[head_q];
                turned_d  = 1'b1;
                head_d    = ptr_inc(head_q);
            end
            if (accept) begin
                q_d[tail_q] = button_state;
                tail_d      = ptr_inc(tail_q);
            end
            if (accept && !pop) begin
                count_d = count_q + 2'd1;
            end else if (pop && !accept) begin
                count_d = count_q - 2'd1;
            end
            if (press_evt && !accept && (drop_q != 8'hFF)) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) q_q[i] <= 2'b00;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= 2'd0;
            heading_q <= RESET_DIR;
            turned_q  <= 1'b0;
            pushed_q  <= 1'b0;
            drop_q    <= 8'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q_q[i] <= q_d[i];
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            heading_q <= heading_d;
            turned_q  <= turned_d;
            pushed_q  <= pushed_d;
            drop_q    <= drop_d;
        end
    end

    assign heading     = heading_q;
    assign turned      = turned_q;
    assign queue_count = count_q;
`ifdef DIRQ_DROP_COUNT_EN
    assign drop_count  = drop_q;
`else
    logic unused_drop;
    assign unused_drop = ^drop_q;
`endif

endmodule

// File: tb/tb_direction_queue.sv
// Directed bench for direction_queue (DEPTH=2, RESET_DIR=11). Accepted presses
// push their direction onto a scoreboard queue; each popping tick pops it and
// compares against the new heading.
module tb_direction_queue;
    logic       clk = 1'b0;
    logic       reset;
    logic       button_pushed;
    logic [1:0] button_state;
    logic       tick;
    logic       flush;
    logic [1:0] heading;
    logic       turned;
    logic [1:0] queue_count;
`ifdef DIRQ_DROP_COUNT_EN
    logic [7:0] drop_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] sb [$];
    int exp_drop = 0;

    direction_queue #(.DEPTH(2), .RESET_DIR(2'b11)) dut (
        .clk          (clk),
        .reset        (reset),
        .button_pushed(button_pushed),
        .button_state (button_state),
        .tick         (tick),
        .flush        (flush),
        .heading      (heading),
        .turned       (turned),
`ifdef DIRQ_DROP_COUNT_EN
        .drop_count   (drop_count),
`endif
        .queue_count  (queue_count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_drop(input string tag);
`ifdef DIRQ_DROP_COUNT_EN
        check(tag, int'(drop_count), exp_drop);
`endif
    endtask

    // one-cycle press followed by one-cycle release
    task automatic press(input logic [1:0] d, input bit accepted);
        button_pushed = 1'b1;
        button_state  = d;
        cyc();
        button_pushed = 1'b0;
        cyc();
        if (accepted) sb.push_back(d);
        else exp_drop++;
    endtask

    // tick; on a pop the scoreboard supplies the expected heading
    task automatic do_tick(input string tag);
        logic [1:0] exp_h;
        bit         exp_t;
        exp_t = (sb.size() != 0);
        exp_h = heading;
        tick  = 1'b1;
        cyc();
        tick  = 1'b0;
        if (exp_t) exp_h = sb.pop_front();
        check({tag, "_turned"}, int'(turned), int'(exp_t));
        check({tag, "_heading"}, int'(heading), int'(exp_h));
    endtask

    initial begin
        reset = 1'b1; button_pushed = 1'b0; button_state = 2'b00;
        tick = 1'b0; flush = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        repeat (10) cyc();
        check("rst_heading", int'(heading), 3);
        check("rst_turned", int'(turned), 0);
        check("rst_count", int'(queue_count), 0);
        check_drop("rst_drop");

        // opposite of right is rejected
        press(2'b10, 1'b0);
        check("opp_count", int'(queue_count), 0);
        do_tick("opp_tick");
        check_drop("opp_drop");

        // same direction as heading is rejected
        press(2'b11, 1'b0);
        check("same_count", int'(queue_count), 0);
        check_drop("same_drop");

        // double turn: up then left
        press(2'b00, 1'b1);
        check("dbl_count1", int'(queue_count), 1);
        press(2'b10, 1'b1);
        check("dbl_count2", int'(queue_count), 2);
        do_tick("dbl_t1");
        do_tick("dbl_t2");
        cyc();
        check("dbl_turned_off", int'(turned), 0);
        check("dbl_empty", int'(queue_count), 0);

        // fill queue (heading left): up, then left
        press(2'b00, 1'b1);
        press(2'b10, 1'b1);
        check("full_count", int'(queue_count), 2);
        press(2'b01, 1'b0);
        check("full_drop_count", int'(queue_count), 2);
        check_drop("full_drop");
        // same press with a tick: pop frees a slot, ref stays the tail (left)
        button_pushed = 1'b1; button_state = 2'b01; tick = 1'b1;
        cyc();
        button_pushed = 1'b0; tick = 1'b0;
        check("pt_turned", int'(turned), 1);
        check("pt_heading", int'(heading), int'(sb.pop_front()));
        sb.push_back(2'b01);
        check("pt_count", int'(queue_count), 2);
        check_drop("pt_drop");
        cyc();
        do_tick("drain1");
        do_tick("drain2");
        check("drain_count", int'(queue_count), 0);

        // flush back to right, then hold up for 20 cycles
        flush = 1'b1; cyc(); flush = 1'b0;
        exp_drop = 0;
        check("fl_heading", int'(heading), 3);
        button_pushed = 1'b1; button_state = 2'b00;
        repeat (20) cyc();
        sb.push_back(2'b00);
        check("hold_count", int'(queue_count), 1);
        do_tick("hold_tick");
        repeat (5) cyc();
        check("hold_no_more", int'(queue_count), 0);
        check_drop("hold_drop");
        button_pushed = 1'b0;
        cyc();

        // heading up: queue left then up, then flush with tick and press
        press(2'b10, 1'b1);
        press(2'b00, 1'b1);
        check("pf_count", int'(queue_count), 2);
        flush = 1'b1; tick = 1'b1; button_pushed = 1'b1; button_state = 2'b01;
        cyc();
        flush = 1'b0; tick = 1'b0; button_pushed = 1'b0;
        sb.delete();
        exp_drop = 0;
        check("pf_heading", int'(heading), 3);
        check("pf_count0", int'(queue_count), 0);
        check("pf_turned", int'(turned), 0);
        check_drop("pf_drop");
        cyc();
        do_tick("pf_idle_tick");

        // reset mid-operation loses buffered presses
        press(2'b00, 1'b1);
        check("mr_count", int'(queue_count), 1);
        reset = 1'b1; cyc(); reset = 1'b0;
        sb.delete();
        exp_drop = 0;
        check("mr_count0", int'(queue_count), 0);
        check("mr_heading", int'(heading), 3);
        check_drop("mr_drop");
        do_tick("mr_tick");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/direction_queue.md
# direction_queue

Consumes one-hot-decoded button events and produces the worm's registered heading, one heading change per game tick. Sits directly downstream of the button synchroniser/decoder and upstream of the worm movement engine. Each press becomes a single event. Presses that would reverse the worm 180° are rejected, and redundant presses are dropped. Valid presses are buffered between ticks so that quick double-turns are not lost.

## Interface
Parameters:
- DEPTH, 2, queue entries; legal range 1..3.
- RESET_DIR, 2'b11, heading loaded on reset and on flush.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- button_pushed  input  1  level; high while exactly one button is held.
- button_state  input  2  direction while button_pushed is high: 00 up, 01 down, 10 left, 11 right.
- tick  input  1  single-cycle game-step strobe.
- flush  input  1  single-cycle game-restart strobe.
- heading  output  2  current worm direction, same encoding as button_state.
- turned  output  1  one-cycle pulse: heading changed on the last tick.
- queue_count  output  2  number of occupied queue entries, 0..DEPTH.
- drop_count  output  8  present only with DIRQ_DROP_COUNT_EN; see Configuration.

## Operation
- Press event:
  - Registers pushed_d <= button_pushed.
  - event = button_pushed & ~pushed_d.
  - A held button produces exactly one event. Re-pressing requires button_pushed to go low for at least one cycle.
- Reference direction ref:
  - When the queue is non-empty, ref = tail entry (last pushed).
  - When the queue is empty, ref = heading.
  - ref uses pre-tick state in all cases.
- Opposite direction: opp(d) = d ^ 2'b01, so up↔down and left↔right.
- Accept rule for an event with direction d:
  - Reject if d == ref.
  - Reject if d == opp(ref).
  - Reject if the queue is full, unless the same-cycle tick pops an entry.
  - Otherwise, push d into the queue.
- Tick:
  - Queue non-empty: pop the head, heading <= head, turned <= 1.
  - Queue empty: heading unchanged, turned <= 0.
- Simultaneous event and tick in the same cycle:
  - The pop and the push both occur, so queue_count is net unchanged.
  - An event arriving with a full queue is accepted if the tick frees a slot.
- Flush:
  - Queue emptied, heading <= RESET_DIR, turned <= 0.
  - Any same-cycle event and any same-cycle tick are ignored.
  - pushed_d still updates.
- Priority order: reset > flush > tick/event.
- Queue implementation:
  - Circular buffer with head and tail pointers that wrap modulo DEPTH.
  - Separate occupancy count, so full and empty are unambiguous.

## Timing
- Reset values: heading = RESET_DIR, turned = 0, queue_count = 0, drop_count = 0, pushed_d = 0, pointers = 0.
- Press to queue: event in cycle N. queue_count reflects the push at N+1.
- Tick to heading: tick in cycle T. heading and turned are valid at T+1.
- turned lasts exactly one cycle unless the next cycle is also a popping tick.
- Minimum press-to-heading latency: press at N, tick at N+1, heading at N+2.
- Reset asserted mid-operation: all state returns to reset values on the next edge. Buffered presses are lost.
- A button held across reset produces no event until it is released and pressed again, because pushed_d is cleared on reset.

## Configuration
- Macro: DIRQ_DROP_COUNT_EN.
- Defined:
  - Output drop_count[7:0] exists.
  - It increments by 1 for every rejected event (same, opposite, or full).
  - It saturates at 255.
  - It is cleared by reset and by flush.
- Undefined:
  - The drop_count port and its counter logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then no stimulus for 10 cycles → heading = 11, turned = 0, queue_count = 0.
- heading = 11 (right); press 10 (left), then tick → event rejected, queue_count stays 0, heading stays 11, drop_count = 1.
- Press 00 (up), release, press 10 (left), then tick, then tick:
  - queue_count = 2 before the ticks.
  - heading = 00 with turned = 1 after the first tick.
  - heading = 10 with turned = 1 after the second tick.
- DEPTH = 2 with the queue full (00 then 10 pending): press 01 → dropped, drop_count increments. Repeat the press in the same cycle as a tick → accepted, queue_count stays 2.
- Hold 00 for 20 cycles with heading = 11 → exactly one entry queued. A tick then gives heading = 00. No further entries are queued while the button remains held.
- Queue holding 2 entries; assert flush together with a tick and a press → heading = 11, queue_count = 0, turned = 0, drop_count = 0.
